poly_stream_src: RTL and testbench
==================================

# poly_stream_src

Coefficient source for the FV encryption datapath. It holds one Rq polynomial `p` (QW-bit coefficients) and one R2 polynomial `u` (UW-bit coefficients), loaded through a simple write port. On a start pulse it streams both polynomials, coefficient 0 first, in lockstep on two AXI-stream outputs, one coefficient per accepted beat. It is the transmitting end of the `p`/`u` stream inputs of the polynomial multiplier and drives `last` on coefficient N-1.

## Interface
- N, 4, coefficients per polynomial; power of two, ≥2
- QW, 5, `p` coefficient width (Q = 2^QW)
- UW, 1, `u` coefficient width
- clk  in  1  single system clock, all logic on rising edge
- a_rst_n  in  1  reset, asynchronous assert, active low; one clock, reset asynchronous active-low
- wr_en  in  1  write strobe for coefficient buffers
- wr_addr  in  $clog2(N)  coefficient index to write
- wr_p  in  QW  `p` coefficient to store at wr_addr
- wr_u  in  UW  `u` coefficient to store at wr_addr
- start  in  1  single-cycle request to stream the stored pair
- busy  out  1  high from the cycle after an accepted start until the final beat is accepted
- done  out  1  one-cycle pulse after the final beat is accepted
- p  axis_if.out  data QW  `p` stream: data, vld, last out; rdy in
- u  axis_if.out  data UW  `u` stream: data, vld, last out; rdy in

## Operation
- Storage: two N-entry arrays, p_mem[N] of QW bits and u_mem[N] of UW bits. Reset clears both to 0.
- Writes: when wr_en=1 and state=ST_IDLE, p_mem[wr_addr]←wr_p and u_mem[wr_addr]←wr_u. When wr_en=1 in any other state, the write is dropped.
- FSM has three states:
  - ST_IDLE
    - On start=1: idx←0, then go to ST_STREAM.
    - If wr_en and start are high in the same cycle, the write lands first, so the new value is streamed.
  - ST_STREAM
    - p.vld and u.vld are both 1. p.data=p_mem[idx], u.data=u_mem[idx].
    - p.last and u.last are 1 only when idx==N-1.
    - A beat is accepted only when p.rdy && u.rdy; a single rdy alone does not advance.
    - On accept with idx<N-1: idx←idx+1.
    - On accept with idx==N-1: vld←0, last←0, then go to ST_DONE.
  - ST_DONE: done=1 for exactly one cycle, then return to ST_IDLE.
- start outside ST_IDLE is ignored; there is no queueing.
- vld, data and last never depend combinationally on rdy. While vld=1 and the beat is not accepted, data and last hold stable.
- idx is $clog2(N) bits. It never wraps during a stream, because the exit condition is idx==N-1.
- Both streams always carry identical vld and last. The multiplier requires p.vld && u.vld in the same cycle.
- Outputs are registered: p.data, u.data, vld, last, busy and done all come from flops.

## Timing
- Reset values: p.vld=u.vld=0, p.last=u.last=0, p.data=u.data=0, busy=0, done=0, state=ST_IDLE, idx=0.
- Reset asserted mid-stream clears every output immediately (asynchronously). No partial stream resumes after reset.
- Start latency: start sampled at edge t gives vld=1 with coefficient 0 visible after edge t (cycle t+1). busy rises in the same cycle.
- With rdy held at 1, N beats occur on N consecutive cycles, and last is on beat N-1.
  - vld falls and done=1 in the cycle after the final accept. busy falls in that same cycle.
- Total time with continuous rdy: start at cycle t, then busy for N cycles, done in cycle t+N+1.
- Back-pressure: each cycle with !(p.rdy && u.rdy) adds one cycle. Data is unchanged across stall cycles.
- The multiplier's rdy is registered and drops after the last beat. That is tolerated, because this block does not assert vld until the next start.
- The earliest following start is the cycle done is high plus one, i.e. start sampled in ST_IDLE.

## Test plan
- Load and stream, N=4, QW=5: write p={3,7,0,31} and u={1,0,1,1}, pulse start, hold rdy=1.
  - Beats (p,u) = (3,1),(7,0),(0,1),(31,1) on 4 consecutive cycles.
  - last on the 4th beat only; done one cycle later.
- Back-pressure: same data, with p.rdy=1 and u.rdy toggling 1,0,0,1,1,0,1.
  - Exactly 4 accepted beats in order, with data and last stable during each stall.
  - No beat is accepted while u.rdy=0.
- Ignored inputs:
  - wr_en with wr_p=9 at idx 1 during a stream: neither the current stream nor the next one shows 9 at idx 1.
  - start during busy: no second stream and no extra done.
- Async reset mid-stream after beat 2: vld, last, busy and done are 0 immediately without a clock edge, and memories read 0.
  - A following start with no writes streams four (0,0) beats.
- Back-to-back with the multiplier model (rdy registered, low for one cycle after last):
  - Two consecutive start/stream sequences each deliver exactly N beats.
  - done is pulsed twice and no beat is lost.
- Same-cycle wr_en and start (addr 0, wr_p=5): first streamed beat has p.data=5.

Source files
------------

// File: rtl/poly_stream_src_if.sv
// axis_if: minimal AXI-stream bundle (data/vld/last forward, rdy backward)
interface axis_if #(parameter int W = 1);
    logic [W-1:0] data;
    logic         vld;
    logic         last;
    logic         rdy;
    modport out (output data, vld, last, input rdy);
    modport in  (input data, vld, last, output rdy);
endinterface

// File: rtl/poly_stream_src.sv
// poly_stream_src: stores one Rq and one R2 polynomial and streams them in lockstep
module poly_stream_src #(
    parameter int N  = 4,
    parameter int QW = 5,
    parameter int UW = 1
) (
    input  logic                 clk,
    input  logic                 a_rst_n,
    input  logic                 wr_en,
    input  logic [$clog2(N)-1:0] wr_addr,
    input  logic [QW-1:0]        wr_p,
    input  logic [UW-1:0]        wr_u,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    axis_if.out                  p,
    axis_if.out                  u
);
    localparam int AW = $clog2(N);
    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DONE} state_t;
    state_t        state_q;
    logic [QW-1:0] p_mem_q [N];
    logic [UW-1:0] u_mem_q [N];
    logic [AW-1:0] idx_q;
    logic [AW-1:0] idx_d;
    logic [QW-1:0] p_data_q;
    logic [UW-1:0] u_data_q;
    logic          vld_q;
    logic          last_q;
    logic          busy_q;
    logic          done_q;
    logic          acc;
    logic          wr0;
    assign acc   = p.rdy && u.rdy;
    assign idx_d = idx_q + 1'b1;
    // a write to entry 0 in the start cycle must reach the first beat
    assign wr0   = wr_en && (wr_addr == '0);
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            p_data_q <= '0;
            u_data_q <= '0;
            vld_q    <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                p_mem_q[i] <= '0;
                u_mem_q[i] <= '0;
            end
        end else begin
            if (wr_en && state_q == ST_IDLE) begin
                p_mem_q[wr_addr] <= wr_p;
                u_mem_q[wr_addr] <= wr_u;
            end
            case (state_q)
                ST_IDLE: if (start) begin
                    state_q  <= ST_STREAM;
                    idx_q    <= '0;
                    vld_q    <= 1'b1;
                    last_q   <= 1'b0;
                    busy_q   <= 1'b1;
                    p_data_q <= wr0 ? wr_p : p_mem_q[0];
                    u_data_q <= wr0 ? wr_u : u_mem_q[0];
                end
                ST_STREAM: if (acc) begin
                    if (idx_q == AW'(N - 1)) begin
                        state_q  <= ST_DONE;
                        vld_q    <= 1'b0;
                        last_q   <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        p_data_q <= '0;
                        u_data_q <= '0;
                    end else begin
                        idx_q    <= idx_d;
                        last_q   <= (idx_d == AW'(N - 1));
                        p_data_q <= p_mem_q[idx_d];
                        u_data_q <= u_mem_q[idx_d];
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
    assign p.data = p_data_q;
    assign u.data = u_data_q;
    assign p.vld  = vld_q;
    assign u.vld  = vld_q;
    assign p.last = last_q;
    assign u.last = last_q;
    assign busy   = busy_q;
    assign done   = done_q;
endmodule

// File: tb/tb_poly_stream_src.sv
// tb_poly_stream_src: directed vectors for the dual coefficient streamer
module tb_poly_stream_src;
    localparam int N = 4;
    logic       clk = 1'b0;
    logic       a_rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [4:0] wr_p = '0;
    logic [0:0] wr_u = '0;
    logic       start = 1'b0;
    logic       busy, done;
    logic       pr = 1'b1, ur = 1'b1, mul = 1'b0, mrdy = 1'b1;
    int         vecs = 0, miss = 0;
    logic [4:0] exp_p [N];
    logic [0:0] exp_u [N];
    logic       pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    axis_if #(.W(5)) p_if ();
    axis_if #(.W(1)) u_if ();

    poly_stream_src #(.N(N), .QW(5), .UW(1)) dut (
        .clk(clk), .a_rst_n(a_rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_p(wr_p), .wr_u(wr_u), .start(start), .busy(busy), .done(done),
        .p(p_if), .u(u_if)
    );

    always #5 clk = ~clk;
    assign p_if.rdy = mul ? mrdy : pr;
    assign u_if.rdy = mul ? mrdy : ur;
    // multiplier model: registered rdy, low for one cycle after the last beat
    always @(posedge clk) mrdy <= !(p_if.vld && p_if.last && p_if.rdy && u_if.rdy);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [4:0] pv, input logic uv);
        wr_en = 1'b1; wr_addr = a; wr_p = pv; wr_u = uv;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: rdy=1, 1: u.rdy pattern, 2: rdy=1 plus ignored write/start, 3: multiplier rdy
    task automatic run(input int mode, input int ecyc, input string nm);
        int beat = 0;
        int k = 0;
        bit held = 0;
        logic [4:0] hp = '0;
        logic hu = 1'b0, hl = 1'b0;
        while (beat < N && k < 40) begin
            pr = 1'b1;
            ur = (mode == 1 && k < 7) ? pat[k] : 1'b1;
            if (mode == 2) begin
                wr_en = (k == 0); wr_addr = 2'd1; wr_p = 5'd9; wr_u = 1'b0; start = (k == 0);
            end
            #1;
            chk({nm, "_vld"}, {p_if.vld, u_if.vld}, 2'b11);
            chk({nm, "_busy"}, busy, 1);
            if (held) begin
                chk({nm, "_stall_p"}, p_if.data, hp);
                chk({nm, "_stall_u"}, u_if.data, hu);
                chk({nm, "_stall_last"}, p_if.last, hl);
            end
            if (p_if.rdy && u_if.rdy) begin
                chk({nm, "_p"}, p_if.data, exp_p[beat]);
                chk({nm, "_u"}, u_if.data, exp_u[beat]);
                chk({nm, "_last"}, {p_if.last, u_if.last}, (beat == N - 1) ? 2'b11 : 2'b00);
                beat++;
                held = 0;
            end else begin
                held = 1; hp = p_if.data; hu = u_if.data; hl = p_if.last;
            end
            k++;
            tick();
        end
        wr_en = 1'b0; start = 1'b0; ur = 1'b1;
        chk({nm, "_beats"}, beat, N);
        chk({nm, "_cycles"}, k, ecyc);
        chk({nm, "_done"}, done, 1);
        chk({nm, "_end_vld"}, {p_if.vld, u_if.vld, p_if.last, busy}, 0);
        tick();
        chk({nm, "_done_pulse"}, {done, p_if.vld, busy}, 0);
    endtask

    initial begin
        #2;
        chk("rst_out", {p_if.vld, u_if.vld, p_if.last, u_if.last, busy, done}, 0);
        chk("rst_data", {p_if.data, u_if.data}, 0);
        #10 a_rst_n = 1'b1;
        tick();
        chk("idle", {p_if.vld, busy, done}, 0);
        exp_p = '{5'd3, 5'd7, 5'd0, 5'd31};
        exp_u = '{1'b1, 1'b0, 1'b1, 1'b1};
        wr(2'd0, 5'd3, 1'b1);
        wr(2'd1, 5'd7, 1'b0);
        wr(2'd2, 5'd0, 1'b1);
        wr(2'd3, 5'd31, 1'b1);
        go();
        run(0, 4, "basic");
        go();
        run(1, 7, "bp");
        go();
        run(2, 4, "ign");
        tick();
        chk("no_restart", {done, p_if.vld, busy}, 0);
        go();
        run(0, 4, "after_ign");
        mul = 1'b1;
        go();
        run(3, 4, "mul1");
        go();
        run(3, 4, "mul2");
        mul = 1'b0;
        go();
        tick();
        tick();
        chk("mid_vld", p_if.vld, 1);
        chk("mid_p", p_if.data, 0);
        #2 a_rst_n = 1'b0;
        #1;
        chk("arst_out", {p_if.vld, u_if.vld, p_if.last, u_if.last, busy, done}, 0);
        chk("arst_data", {p_if.data, u_if.data}, 0);
        #2 a_rst_n = 1'b1;
        tick();
        chk("arst_idle", {p_if.vld, busy, done}, 0);
        exp_p = '{5'd0, 5'd0, 5'd0, 5'd0};
        exp_u = '{1'b0, 1'b0, 1'b0, 1'b0};
        go();
        run(0, 4, "zero");
        wr_en = 1'b1; wr_addr = 2'd0; wr_p = 5'd5; wr_u = 1'b1; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        exp_p = '{5'd5, 5'd0, 5'd0, 5'd0};
        exp_u = '{1'b1, 1'b0, 1'b0, 1'b0};
        run(0, 4, "wrstart");
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
